// File: rtl/sseg_scan_if.sv
// +----------------------------------------------------------------------------+
// | sseg_scan_if : shadow-load / display-output bundle of sseg_scan_driver     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sseg_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    en;
  logic                    lzb;
  logic [3:0]              hex_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    slot_tick;

  modport master (
    output load, value_in, dp_in, en, lzb,
    input  hex_out, dp_out, an, slot_tick
  );

  modport slave (
    input  load, value_in, dp_in, en, lzb,
    output hex_out, dp_out, an, slot_tick
  );
endinterface

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
// +----------------------------------------------------------------------------+
// | sseg_scan_driver : time-multiplexed seven-segment scan controller with     |
// | anti-ghost blanking and leading-zero suppression.              Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sseg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 100000,
  parameter int BLANK_CYC     = 16,
  parameter int AN_ACTIVE_LOW = 0
) (
  input wire          clk,
  input wire          rst_n,
  sseg_scan_if.slave  bus
);

  localparam int c_pw = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_sw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_pw-1:0] c_presc_last = c_pw'(SCAN_DIV - 1);
  localparam logic [c_pw-1:0] c_blank      = c_pw'(BLANK_CYC);
  localparam logic [c_sw-1:0] c_sel_last   = c_sw'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [c_pw-1:0]         r_presc;
  logic [c_sw-1:0]         r_sel;

  logic                    w_tick;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS:1]     w_zero_from;
  logic [3:0]              w_hex;
  logic                    w_dp;
  logic                    w_blank_cur;
  logic                    w_an_on;
  logic [NUM_DIGITS-1:0]   w_an_hot;

  assign w_tick = bus.en & (r_presc == c_presc_last);

  // Shadow capture is independent of en so data can be staged while dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_dp    <= '0;
    end else if (bus.load) begin
      r_value <= bus.value_in;
      r_dp    <= bus.dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sel   <= '0;
    end else if (bus.en) begin
      if (w_tick) begin
        r_presc <= '0;
        r_sel   <= (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // w_zero_from[i]: nibbles i..NUM_DIGITS-1 are all zero.
  assign w_zero_from[NUM_DIGITS] = 1'b1;
  assign w_blank[0]              = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign w_zero_from[gi] = (r_value[4*gi +: 4] == 4'h0) & w_zero_from[gi+1];
      assign w_blank[gi]     = bus.lzb & w_zero_from[gi] & ~r_dp[gi];
    end
  endgenerate

  always_comb begin
    w_hex       = 4'h0;
    w_dp        = 1'b0;
    w_blank_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == c_sw'(i)) begin
        w_hex       = r_value[4*i +: 4];
        w_dp        = r_dp[i];
        w_blank_cur = w_blank[i];
      end
    end
  end

  // rst_n gating keeps the digits dark during reset even with BLANK_CYC = 0.
  assign w_an_on = rst_n & bus.en & (r_presc >= c_blank) & ~w_blank_cur;

  always_comb begin
    w_an_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == c_sw'(i)) begin
        w_an_hot[i] = w_an_on;
      end
    end
  end

  generate
    if (AN_ACTIVE_LOW != 0) begin : g_an_low
      assign bus.an = ~w_an_hot;
    end else begin : g_an_high
      assign bus.an = w_an_hot;
    end
  endgenerate

  assign bus.hex_out   = w_hex;
  assign bus.dp_out    = w_dp;
  assign bus.slot_tick = w_tick;

endmodule

`default_nettype wire
